lap_capture: RTL and testbench
==============================

// Module: lap_capture
// PURPOSE
//   Conditions the raw laser_detector input and decides when a beam break is a valid lap crossing.
//   First crossing after reset starts the lap timer. Each later crossing, if the lap is at least
//   MIN_LAP_SEC long, latches the timer value as the last lap, tracks the best lap, counts laps
//   and issues a one-cycle reset pulse to the timer.
//   Sits between the laser input pin and the timer/LED stages. Replaces the ad-hoc start/5-second triggers.
// PARAMETERS
//   DEB_CYCLES   500000  consecutive master_clk cycles a synced level must hold to be accepted (10 ms @ 50 MHz)
//   DEB_BIT      19      MSB index of debounce counter; 2**(DEB_BIT+1) > DEB_CYCLES
//   MIN_LAP_SEC  5       minimum lap length in seconds; crossings earlier than this are ignored
//   LAP_MAX      99      saturation value of lap_count
// PORTS
//   master_clk      in   1  system clock, all logic on posedge
//   rs              in   1  asynchronous active-high reset
//   laser_detector  in   1  raw beam input, asynchronous; 0 = beam broken
//   minutes         in   7  running timer minutes, 0..59
//   seconds         in   7  running timer seconds, 0..59
//   milliseconds    in   7  running timer hundredths, 0..99
//   enable          out  1  timer run enable; high from lap start until reset
//   lap_rs          out  1  one-cycle pulse that clears the timer at the end of an accepted lap
//   last_min/last_sec/last_cs  out 7 each  time of the most recent accepted lap
//   best_min/best_sec/best_cs  out 7 each  time of the fastest accepted lap
//   best_valid      out  1  high once at least one lap has been recorded
//   new_best        out  1  one-cycle pulse when best_* was updated
//   lap_count       out  7  accepted laps, saturates at LAP_MAX
// BEHAVIOUR
//   Reset (async, rs=1): all outputs 0. FSM goes to IDLE. Sync flops are set to 1 (beam intact).
//     The debounced level is set to 1 and the debounce counter to 0.
//   Input path: 2-flop synchroniser -> laser_sync. A counter counts cycles where laser_sync
//     differs from the debounced level and clears on any cycle where they agree. When the count
//     reaches DEB_CYCLES, the debounced level flips and the counter clears.
//     crossing = 1-cycle pulse on the 1->0 flip of the debounced level. The 0->1 flip re-arms,
//     so a held break produces exactly one crossing. Glitches shorter than DEB_CYCLES never flip the level.
//   Eligibility: elig = (minutes != 0) | (seconds >= MIN_LAP_SEC), evaluated in the crossing cycle.
//   FSM states: IDLE, RUN, CAPT
//     IDLE: enable=0. On crossing -> RUN, and enable goes to 1 on the same edge.
//     RUN: enable=1. On crossing & elig -> CAPT. On crossing & !elig: stay in RUN, nothing changes.
//     CAPT: lasts exactly 1 cycle, lap_rs=1, then -> RUN. A crossing in CAPT is dropped.
//   Capture timing: on the edge that enters CAPT, all of the following happen together:
//     last_* <= {minutes,seconds,milliseconds} sampled in the crossing cycle.
//     lap_count increments, unless it is already LAP_MAX.
//     If !best_valid, or the packed value {min,sec,cs} (21-bit unsigned) is strictly less than
//       the packed best_* value: best_* <= captured time, best_valid <= 1, new_best <= 1 for the CAPT cycle.
//     A lap equal to the current best does not update best and does not pulse new_best.
//   Latency: last_*, best_* and lap_count are visible in the CAPT cycle.
//     lap_rs is high in the CAPT cycle. The timer reads 0 from the next cycle onward.
//   enable stays 1 through CAPT, so the timer runs continuously across laps.
//   An rs assertion mid-lap or during CAPT clears everything immediately. Recording restarts from IDLE.
// TESTING
//   1. Reset, laser=1 steady -> enable=0, all outputs 0, state IDLE; hold 2*DEB_CYCLES, nothing changes.
//   2. Break beam for DEB_CYCLES-1 cycles then restore -> no crossing, enable stays 0.
//      Break for DEB_CYCLES+10 -> enable=1 exactly 2+DEB_CYCLES+1 cycles after the raw fall.
//   3. RUN with timer at 0:03.50, valid break -> ignored, lap_count=0, no lap_rs.
//      Same break at 0:07.25 -> last=0:07.25, best=0:07.25, best_valid=1, new_best=1,
//      lap_rs one cycle, lap_count=1.
//   4. Laps 0:07.25, then 0:06.10, then 0:06.10 -> best=0:06.10; new_best pulses on laps 1 and 2
//      only; lap_count=3; last=0:06.10.
//   5. Lap at 1:02.00 (seconds < 5, minutes != 0) -> accepted, last=1:02.00, best unchanged if best < 1:02.00.
//   6. Assert rs during the CAPT cycle -> all outputs 0 at once; the next valid break restarts from IDLE
//      with lap_count=0. Also run 101 laps -> lap_count saturates at 99.
//   Use DEB_CYCLES=8, DEB_BIT=3 in simulation; drive minutes/seconds/milliseconds directly from the bench.

Source files
------------

// File: rtl/lap_capture.sv
// Lap crossing detector: synchronises and debounces the laser beam input, then runs the
// IDLE/RUN/CAPT sequence that latches lap times, tracks the best lap and clears the timer.
module lap_capture #(
    parameter int DEB_CYCLES  = 500000,
    parameter int DEB_BIT     = 19,
    parameter int MIN_LAP_SEC = 5,
    parameter int LAP_MAX     = 99
) (
    input  logic       master_clk,
    input  logic       rs,
    input  logic       laser_detector,
    input  logic [6:0] minutes,
    input  logic [6:0] seconds,
    input  logic [6:0] milliseconds,
    output logic       enable,
    output logic       lap_rs,
    output logic [6:0] last_min,
    output logic [6:0] last_sec,
    output logic [6:0] last_cs,
    output logic [6:0] best_min,
    output logic [6:0] best_sec,
    output logic [6:0] best_cs,
    output logic       best_valid,
    output logic       new_best,
    output logic [6:0] lap_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;

    localparam int               DEB_LAST_INT = DEB_CYCLES - 1;
    localparam logic [DEB_BIT:0] DEB_LAST     = DEB_LAST_INT[DEB_BIT:0];
    localparam logic [6:0]       MIN_SEC      = MIN_LAP_SEC[6:0];
    localparam logic [6:0]       LAP_CAP      = LAP_MAX[6:0];

    logic             sync1;
    logic             laser_sync;
    logic             deb_level;
    logic [DEB_BIT:0] deb_cnt;
    logic             crossing;
    logic [1:0]       state;
    logic             elig;
    logic [20:0]      cur_time;
    logic [20:0]      best_time;

    // Sync flops reset to 1 so a freshly reset system sees an intact beam.
    always_ff @(posedge master_clk or posedge rs) begin
        if (rs) begin
            sync1      <= 1'b1;
            laser_sync <= 1'b1;
        end else begin
            sync1      <= laser_detector;
            laser_sync <= sync1;
        end
    end

    // Level only flips after DEB_CYCLES consecutive disagreeing cycles; crossing fires on 1->0 only.
    always_ff @(posedge master_clk or posedge rs) begin
        if (rs) begin
            deb_level <= 1'b1;
            deb_cnt   <= '0;
            crossing  <= 1'b0;
        end else begin
            crossing <= 1'b0;
            if (laser_sync == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= laser_sync;
                deb_cnt   <= '0;
                crossing  <= deb_level;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign elig      = (minutes != 7'd0) || (seconds >= MIN_SEC);
    assign cur_time  = {minutes, seconds, milliseconds};
    assign best_time = {best_min, best_sec, best_cs};

    // All lap results are registered on the edge entering CAPT so they appear with lap_rs.
    always_ff @(posedge master_clk or posedge rs) begin
        if (rs) begin
            state      <= IDLE;
            enable     <= 1'b0;
            lap_rs     <= 1'b0;
            last_min   <= '0;
            last_sec   <= '0;
            last_cs    <= '0;
            best_min   <= '0;
            best_sec   <= '0;
            best_cs    <= '0;
            best_valid <= 1'b0;
            new_best   <= 1'b0;
            lap_count  <= '0;
        end else begin
            lap_rs   <= 1'b0;
            new_best <= 1'b0;
            case (state)
                IDLE: begin
                    if (crossing) begin
                        state  <= RUN;
                        enable <= 1'b1;
                    end
                end
                RUN: begin
                    if (crossing && elig) begin
                        state    <= CAPT;
                        lap_rs   <= 1'b1;
                        last_min <= minutes;
                        last_sec <= seconds;
                        last_cs  <= milliseconds;
                        if (lap_count != LAP_CAP) begin
                            lap_count <= lap_count + 7'd1;
                        end
                        if (!best_valid || (cur_time < best_time)) begin
                            best_min   <= minutes;
                            best_sec   <= seconds;
                            best_cs    <= milliseconds;
                            best_valid <= 1'b1;
                            new_best   <= 1'b1;
                        end
                    end
                end
                CAPT: begin
                    state <= RUN;
                end
                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lap_capture.sv
// Self-checking bench for lap_capture: debounce timing, lap acceptance table, best-lap tracking,
// reset during capture and lap_count saturation, with a queue-based scoreboard for lap results.
module tb_lap_capture;

    localparam int DEB     = 8;
    localparam int LAT     = 2 + DEB + 1;
    localparam int REARM   = DEB + 4;

    logic       master_clk = 1'b0;
    logic       rs;
    logic       laser_detector;
    logic [6:0] minutes, seconds, milliseconds;
    logic       enable, lap_rs, best_valid, new_best;
    logic [6:0] last_min, last_sec, last_cs, best_min, best_sec, best_cs, lap_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int m, s, c;
        int accept;
        int nb;
        int bm, bs, bc;
        int bv;
        int cnt;
    } lap_vec_t;

    typedef struct {
        int lm, ls, lc, bm, bs, bc, bv, nb, lrs, cnt, en;
    } expect_t;

    expect_t  sb_queue[$];
    lap_vec_t vecs[7];
    int exp_lm = 0, exp_ls = 0, exp_lc = 0;

    lap_capture #(
        .DEB_CYCLES(DEB), .DEB_BIT(3), .MIN_LAP_SEC(5), .LAP_MAX(99)
    ) dut (
        .master_clk(master_clk), .rs(rs), .laser_detector(laser_detector),
        .minutes(minutes), .seconds(seconds), .milliseconds(milliseconds),
        .enable(enable), .lap_rs(lap_rs),
        .last_min(last_min), .last_sec(last_sec), .last_cs(last_cs),
        .best_min(best_min), .best_sec(best_sec), .best_cs(best_cs),
        .best_valid(best_valid), .new_best(new_best), .lap_count(lap_count)
    );

    always #5 master_clk = ~master_clk;

    task automatic tick();
        @(posedge master_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, ".enable"}, int'(enable), 0);
        checkOutput({tag, ".lap_rs"}, int'(lap_rs), 0);
        checkOutput({tag, ".last"}, int'({last_min, last_sec, last_cs}), 0);
        checkOutput({tag, ".best"}, int'({best_min, best_sec, best_cs}), 0);
        checkOutput({tag, ".best_valid"}, int'(best_valid), 0);
        checkOutput({tag, ".new_best"}, int'(new_best), 0);
        checkOutput({tag, ".lap_count"}, int'(lap_count), 0);
    endtask

    task automatic restore_beam();
        laser_detector = 1'b1;
        repeat (REARM) tick();
    endtask

    // Drive one beam break at a fixed timer value and queue what the CAPT cycle must show.
    task automatic applyStimulus(input lap_vec_t v, input string tag);
        expect_t e;
        minutes      = 7'(v.m);
        seconds      = 7'(v.s);
        milliseconds = 7'(v.c);
        if (v.accept != 0) begin
            exp_lm = v.m;
            exp_ls = v.s;
            exp_lc = v.c;
        end
        e = '{exp_lm, exp_ls, exp_lc, v.bm, v.bs, v.bc, v.bv, v.nb, v.accept, v.cnt, 1};
        sb_queue.push_back(e);
        laser_detector = 1'b0;
        repeat (LAT) tick();
        if (sb_queue.size() == 0) begin
            checkOutput({tag, ".sb_empty"}, 1, 0);
        end else begin
            e = sb_queue.pop_front();
            checkOutput({tag, ".last"}, int'({last_min, last_sec, last_cs}),
                        (e.lm << 14) | (e.ls << 7) | e.lc);
            checkOutput({tag, ".best"}, int'({best_min, best_sec, best_cs}),
                        (e.bm << 14) | (e.bs << 7) | e.bc);
            checkOutput({tag, ".best_valid"}, int'(best_valid), e.bv);
            checkOutput({tag, ".new_best"}, int'(new_best), e.nb);
            checkOutput({tag, ".lap_rs"}, int'(lap_rs), e.lrs);
            checkOutput({tag, ".lap_count"}, int'(lap_count), e.cnt);
            checkOutput({tag, ".enable"}, int'(enable), e.en);
        end
        tick();
        checkOutput({tag, ".lap_rs_off"}, int'(lap_rs), 0);
        checkOutput({tag, ".new_best_off"}, int'(new_best), 0);
        checkOutput({tag, ".enable_hold"}, int'(enable), 1);
        restore_beam();
    endtask

    initial begin
        int first_en;
        lap_vec_t v;

        vecs[0] = '{0, 3, 50, 0, 0, 0, 0,  0, 0, 0};
        vecs[1] = '{0, 7, 25, 1, 1, 0, 7, 25, 1, 1};
        vecs[2] = '{0, 6, 10, 1, 1, 0, 6, 10, 1, 2};
        vecs[3] = '{0, 6, 10, 1, 0, 0, 6, 10, 1, 3};
        vecs[4] = '{1, 2,  0, 1, 0, 0, 6, 10, 1, 4};
        vecs[5] = '{0, 4, 99, 0, 0, 0, 6, 10, 1, 4};
        vecs[6] = '{0, 5,  0, 1, 1, 0, 5,  0, 1, 5};

        rs = 1'b1;
        laser_detector = 1'b1;
        minutes = '0;
        seconds = '0;
        milliseconds = '0;
        repeat (2) tick();
        check_all_zero("reset");
        rs = 1'b0;
        repeat (2 * DEB) tick();
        check_all_zero("idle_hold");

        // Break one cycle too short: must never register as a crossing.
        laser_detector = 1'b0;
        repeat (DEB - 1) tick();
        restore_beam();
        checkOutput("glitch.enable", int'(enable), 0);

        // Valid start break: enable must rise exactly LAT cycles after the raw fall.
        first_en = -1;
        laser_detector = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (enable && first_en < 0) first_en = i;
        end
        checkOutput("start.latency", first_en, LAT);
        checkOutput("start.lap_count", int'(lap_count), 0);
        checkOutput("start.lap_rs", int'(lap_rs), 0);
        repeat (DEB + 10 - LAT) tick();
        restore_beam();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted in the middle of a CAPT cycle.
        minutes = 7'd0;
        seconds = 7'd8;
        milliseconds = 7'd0;
        laser_detector = 1'b0;
        repeat (LAT) tick();
        checkOutput("capt.lap_rs", int'(lap_rs), 1);
        rs = 1'b1;
        laser_detector = 1'b1;
        #1;
        check_all_zero("rst_in_capt");
        tick();
        rs = 1'b0;
        exp_lm = 0;
        exp_ls = 0;
        exp_lc = 0;
        repeat (REARM) tick();
        checkOutput("post_rst.enable", int'(enable), 0);

        laser_detector = 1'b0;
        repeat (LAT) tick();
        checkOutput("restart.enable", int'(enable), 1);
        checkOutput("restart.lap_count", int'(lap_count), 0);
        checkOutput("restart.lap_rs", int'(lap_rs), 0);
        restore_beam();

        for (int k = 1; k <= 101; k++) begin
            v = '{0, 10, 0, 1, (k == 1) ? 1 : 0, 0, 10, 0, 1, (k > 99) ? 99 : k};
            applyStimulus(v, $sformatf("sat%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
